// File: rtl/bounce_sprite_render.sv
// -----------------------------------------------------------------------------
// bounce_sprite_render
//
// Pixel-generation stage placed after a 480p display timing generator. It
// draws a solid square sprite that moves SPEED pixels per axis once per frame.
// The sprite bounces off the screen edges, and its colour changes on every
// frame in which a bounce happens. The outputs are 2-bit-per-channel RGB plus
// hsync/vsync/de, all delayed by two clocks so they line up with the colour.
//
// Optional build macro:
//   BOUNCE_BORDER_EN - draw a one-pixel white border around the active area.
//                      The sprite still wins wherever it overlaps the border.
//
// Ports:
//   clk_pix, rst_pix_n       pixel clock, asynchronous active-low reset
//   en                       motion enable (0 freezes the sprite, drawing goes on)
//   sx, sy                   signed screen position from the timing generator
//   de, hsync_in, vsync_in   data enable and syncs from the timing generator
//   frame                    one-cycle start-of-frame pulse
//   vga_r, vga_g, vga_b      2-bit colour channels
//   hsync_out, vsync_out     syncs delayed by 2 clocks
//   de_out                   de delayed by 2 clocks
//   bounce_cnt               number of frames that contained a bounce (wraps)
//
// The motion FSM state is visible on the internal signal dbg_state:
// IDLE=0, UPD_X=1, UPD_Y=2, COMMIT=3.
// -----------------------------------------------------------------------------
module bounce_sprite_render #(
  parameter int CORDW  = 16,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int SIZE   = 32,
  parameter int SPEED  = 2,
  parameter int X_INIT = 100,
  parameter int Y_INIT = 60
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    en,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic                    de,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    frame,
  output logic [1:0]              vga_r,
  output logic [1:0]              vga_g,
  output logic [1:0]              vga_b,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    de_out,
  output logic [7:0]              bounce_cnt
);

  // All coordinate arithmetic is done one bit wider than CORDW, so sums and
  // comparisons cannot overflow.
  localparam logic signed [CORDW:0]   SPD    = (CORDW+1)'(SPEED);
  localparam logic signed [CORDW:0]   X_MAX  = (CORDW+1)'(H_RES - SIZE);
  localparam logic signed [CORDW:0]   Y_MAX  = (CORDW+1)'(V_RES - SIZE);
  localparam logic signed [CORDW:0]   SZM1   = (CORDW+1)'(SIZE - 1);
  localparam logic signed [CORDW-1:0] X_RST  = CORDW'(X_INIT);
  localparam logic signed [CORDW-1:0] Y_RST  = CORDW'(Y_INIT);

  typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y, COMMIT} state_e;

  state_e                  state_q, state_d;
  logic signed [CORDW-1:0] qx_q, qx_d;
  logic signed [CORDW-1:0] qy_q, qy_d;
  logic                    dir_x_q, dir_x_d;   // 0 = right, 1 = left
  logic                    dir_y_q, dir_y_d;   // 0 = down,  1 = up
  logic                    hit_q, hit_d;
  logic [2:0]              ci_q, ci_d;
  logic [7:0]              bcnt_q, bcnt_d;

  logic [1:0]              dbg_state;
  assign dbg_state = state_q;

  logic signed [CORDW:0]   qx_e, qy_e, sx_e, sy_e;
  logic signed [CORDW:0]   x_inc, x_dec, y_inc, y_dec;

  assign qx_e  = {qx_q[CORDW-1], qx_q};
  assign qy_e  = {qy_q[CORDW-1], qy_q};
  assign sx_e  = {sx[CORDW-1], sx};
  assign sy_e  = {sy[CORDW-1], sy};
  assign x_inc = qx_e + SPD;
  assign x_dec = qx_e - SPD;
  assign y_inc = qy_e + SPD;
  assign y_dec = qy_e - SPD;

  // ---------------------------------------------------------------------------
  // Motion FSM: one step per axis, then a commit step. The commit step makes a
  // corner bounce count only once.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    qx_d    = qx_q;
    qy_d    = qy_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    hit_d   = hit_q;
    ci_d    = ci_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (frame && en) state_d = UPD_X;
      end
      UPD_X: begin
        if (!dir_x_q) begin
          if (x_inc >= X_MAX) begin
            qx_d    = X_MAX[CORDW-1:0];
            dir_x_d = 1'b1;
            hit_d   = 1'b1;
          end else begin
            qx_d = x_inc[CORDW-1:0];
          end
        end else begin
          if (qx_e <= SPD) begin
            qx_d    = '0;
            dir_x_d = 1'b0;
            hit_d   = 1'b1;
          end else begin
            qx_d = x_dec[CORDW-1:0];
          end
        end
        state_d = UPD_Y;
      end
      UPD_Y: begin
        if (!dir_y_q) begin
          if (y_inc >= Y_MAX) begin
            qy_d    = Y_MAX[CORDW-1:0];
            dir_y_d = 1'b1;
            hit_d   = 1'b1;
          end else begin
            qy_d = y_inc[CORDW-1:0];
          end
        end else begin
          if (qy_e <= SPD) begin
            qy_d    = '0;
            dir_y_d = 1'b0;
            hit_d   = 1'b1;
          end else begin
            qy_d = y_dec[CORDW-1:0];
          end
        end
        state_d = COMMIT;
      end
      COMMIT: begin
        if (hit_q) begin
          ci_d   = ci_q + 3'd1;
          bcnt_d = bcnt_q + 8'd1;
        end
        hit_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q <= IDLE;
      qx_q    <= X_RST;
      qy_q    <= Y_RST;
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      hit_q   <= 1'b0;
      ci_q    <= 3'd0;
      bcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      hit_q   <= hit_d;
      ci_q    <= ci_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign bounce_cnt = bcnt_q;

  // ---------------------------------------------------------------------------
  // Pixel pipeline. Stage 1 computes the hit test and stage 2 computes the
  // colour. The sprite position is read live, because it only moves during
  // blanking.
  // ---------------------------------------------------------------------------
  logic in_sq1_q, in_sq1_d;
  logic de1_q, hs1_q, vs1_q;
  logic [5:0] rgb_q, rgb_d;
  logic de2_q, hs2_q, vs2_q;

  assign in_sq1_d = (sx_e >= qx_e) && (sx_e <= qx_e + SZM1) &&
                    (sy_e >= qy_e) && (sy_e <= qy_e + SZM1);

`ifdef BOUNCE_BORDER_EN
  localparam logic signed [CORDW:0] X_LAST = (CORDW+1)'(H_RES - 1);
  localparam logic signed [CORDW:0] Y_LAST = (CORDW+1)'(V_RES - 1);
  logic border1_q, border1_d;
  assign border1_d = (sx_e == '0) || (sx_e == X_LAST) ||
                     (sy_e == '0) || (sy_e == Y_LAST);
`endif

  always_comb begin
    rgb_d = 6'b00_00_00;
    if (!de1_q) begin
      rgb_d = 6'b00_00_00;
    end else if (in_sq1_q) begin
      rgb_d = {ci_q[0], 1'b1, ci_q[1], 1'b1, ci_q[2], 1'b1};
`ifdef BOUNCE_BORDER_EN
    end else if (border1_q) begin
      rgb_d = 6'b11_11_11;
`endif
    end else begin
      rgb_d = 6'b00_00_01;
    end
  end

  // Syncs idle high, so their pipeline flops reset to 1.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      in_sq1_q  <= 1'b0;
      de1_q     <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
`ifdef BOUNCE_BORDER_EN
      border1_q <= 1'b0;
`endif
      rgb_q     <= 6'b0;
      de2_q     <= 1'b0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
    end else begin
      in_sq1_q  <= in_sq1_d;
      de1_q     <= de;
      hs1_q     <= hsync_in;
      vs1_q     <= vsync_in;
`ifdef BOUNCE_BORDER_EN
      border1_q <= border1_d;
`endif
      rgb_q     <= rgb_d;
      de2_q     <= de1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
    end
  end

  assign vga_r     = rgb_q[5:4];
  assign vga_g     = rgb_q[3:2];
  assign vga_b     = rgb_q[1:0];
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign de_out    = de2_q;

endmodule
